// File: rtl/data_ram.sv
// Byte-addressable single-port data memory with request/response handshake and a
// fixed wait-state count; loads return right-aligned, zero-filled data.
module data_ram #(
  parameter int unsigned SIZE        = 12,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic [SIZE-1:0] req_addr,
  input  logic [31:0]     req_wdata,
  output logic            rsp_valid,
  output logic [31:0]     rsp_rdata,
  output logic            rsp_err
);

  localparam int unsigned DEPTH = 2 ** (SIZE - 2);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [1:0]      size_q, size_d;
  logic [SIZE-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH];

  logic            acc_we;
  logic [1:0]      acc_size;
  logic [SIZE-1:0] acc_addr;
  logic [31:0]     acc_wdata;
  logic            acc_err;
  logic [3:0]      acc_be;
  logic [4:0]      lane_shift;
  logic [31:0]     wword;
  logic [31:0]     rd_shifted;
  logic [31:0]     rd_data;
  logic            commit;

  // With no wait states the commit edge is also the accept edge, so the access
  // must be taken straight from the request inputs rather than the latched copy.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_size  = req_size;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
  end

  always_comb begin
    acc_err = 1'b0;
    acc_be  = '0;
    case (acc_size)
      2'b00: acc_be = 4'b0001 << acc_addr[1:0];
      2'b01: begin
        acc_err = acc_addr[0];
        acc_be  = acc_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        acc_err = |acc_addr[1:0];
        acc_be  = 4'b1111;
      end
      default: acc_err = 1'b1;
    endcase
  end

  assign lane_shift = {acc_addr[1:0], 3'b000};
  assign wword      = acc_wdata << lane_shift;
  assign rd_shifted = mem[acc_addr[SIZE-1:2]] >> lane_shift;

  always_comb begin
    rd_data = '0;
    case (acc_size)
      2'b00:   rd_data = {24'h0, rd_shifted[7:0]};
      2'b01:   rd_data = {16'h0, rd_shifted[15:0]};
      2'b10:   rd_data = rd_shifted;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    commit    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = 4'(WAIT_STATES);
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
          end else begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
          commit  = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? '0 : rd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && commit && acc_we && !acc_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (acc_be[b]) mem[acc_addr[SIZE-1:2]][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_ram.sv
// Randomised and directed checks of data_ram at three wait-state settings against a
// byte-level memory model.
module tb_data_ram;

  logic        clk;
  logic        rst       [3];
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [1:0]  req_size  [3];
  logic [11:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int vectors;
  int miscompares;
  int ws_of [3] = '{1, 0, 3};

  logic [7:0] ref_mem [3][4096];

  data_ram #(.SIZE(12), .WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_size(req_size[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0]));

  data_ram #(.SIZE(12), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_size(req_size[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1]));

  data_ram #(.SIZE(12), .WAIT_STATES(3)) u2 (
    .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_size(req_size[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: memory is a flat byte array, accesses are little-endian byte runs.
  function automatic void mdl(input int ch, input bit we, input logic [1:0] size,
                              input logic [11:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output bit err);
    int n;
    rdata = '0;
    if (size == 2'd3) begin
      err = 1'b1;
      return;
    end
    n   = 1 << size;
    err = (int'(addr) % n) != 0;
    if (err) return;
    for (int i = 0; i < n; i++) begin
      if (we) ref_mem[ch][int'(addr) + i] = wdata[8*i +: 8];
      else    rdata[8*i +: 8] = ref_mem[ch][int'(addr) + i];
    end
  endfunction

  task automatic run_access(input int ch, input bit we, input logic [1:0] size,
                            input logic [11:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output bit err,
                            output int lat, output bit one_pulse);
    int k;
    @(negedge clk);
    req_valid[ch] = 1'b1;
    req_we[ch]    = we;
    req_size[ch]  = size;
    req_addr[ch]  = addr;
    req_wdata[ch] = wdata;
    k = 0;
    while (!req_ready[ch] && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 req_valid[ch] = 1'b0;
    lat = -1; rdata = '0; err = 1'b0; one_pulse = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid[ch]) begin
        lat = c; rdata = rsp_rdata[ch]; err = rsp_err[ch];
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      one_pulse = !rsp_valid[ch];
    end
  endtask

  task automatic test_reset();
    for (int ch = 0; ch < 3; ch++) begin
      rst[ch] = 1'b1; req_valid[ch] = 1'b0; req_we[ch] = 1'b0;
      req_size[ch] = '0; req_addr[ch] = '0; req_wdata[ch] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int ch = 0; ch < 3; ch++) begin
      vectors++;
      if (req_ready[ch] !== 1'b1 || rsp_valid[ch] !== 1'b0 ||
          rsp_rdata[ch] !== 32'h0 || rsp_err[ch] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset ch%0d got ready=%b valid=%b rdata=%h err=%b exp 1 0 0 0",
                 ch, req_ready[ch], rsp_valid[ch], rsp_rdata[ch], rsp_err[ch]);
      end
      rst[ch] = 1'b0;
    end
  endtask

  logic [31:0] d_wd  [10] = '{32'hDEADBEEF, 0, 32'h55, 0, 0, 0, 0, 32'hAAAA5555, 0, 0};
  logic [31:0] d_exp [10] = '{0, 32'hDEADBEEF, 0, 32'hDE55BEEF, 32'hDE, 32'hDE55, 0, 0,
                              32'hDE55BEEF, 0};
  logic [11:0] d_ad  [10] = '{12'h010, 12'h010, 12'h012, 12'h010, 12'h013, 12'h012,
                              12'h011, 12'h012, 12'h010, 12'h000};
  logic [1:0]  d_sz  [10] = '{2, 2, 0, 2, 0, 1, 1, 2, 2, 3};
  bit          d_we  [10] = '{1, 0, 1, 0, 0, 0, 0, 1, 0, 0};
  bit          d_er  [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 1};

  task automatic test_directed();
    logic [31:0] rd, mrd;
    bit er, mer, pulse;
    int lat;
    for (int i = 0; i < 10; i++) begin
      mdl(0, d_we[i], d_sz[i], d_ad[i], d_wd[i], mrd, mer);
      run_access(0, d_we[i], d_sz[i], d_ad[i], d_wd[i], rd, er, lat, pulse);
      vectors++;
      if (rd !== d_exp[i] || er !== d_er[i]) begin
        miscompares++;
        $display("FAIL directed[%0d] got rdata=%h err=%b exp rdata=%h err=%b",
                 i, rd, er, d_exp[i], d_er[i]);
      end
      vectors++;
      if (lat != 2 || !pulse) begin
        miscompares++;
        $display("FAIL directed_timing[%0d] got lat=%0d single=%b exp lat=2 single=1",
                 i, lat, pulse);
      end
      vectors++;
      if (rsp_rdata[0] !== d_exp[i] || rsp_err[0] !== d_er[i]) begin
        miscompares++;
        $display("FAIL directed_hold[%0d] got rdata=%h err=%b exp rdata=%h err=%b",
                 i, rsp_rdata[0], rsp_err[0], d_exp[i], d_er[i]);
      end
    end
  endtask

  task automatic test_random(input int ch, input int n);
    logic [31:0] rd, erd, wd;
    logic [11:0] ad;
    logic [1:0]  sz;
    bit er, eer, pulse, we;
    int lat;
    for (int w = 0; w < 16; w++) begin
      wd = $urandom;
      ad = 12'h100 + 12'(w * 4);
      mdl(ch, 1'b1, 2'd2, ad, wd, erd, eer);
      run_access(ch, 1'b1, 2'd2, ad, wd, rd, er, lat, pulse);
      vectors++;
      if (er !== 1'b0 || lat != ws_of[ch] + 1) begin
        miscompares++;
        $display("FAIL init_store ch%0d addr %h got err=%b lat=%0d exp err=0 lat=%0d",
                 ch, ad, er, lat, ws_of[ch] + 1);
      end
    end
    for (int k = 0; k < n; k++) begin
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      ad = 12'h100 + 12'($urandom_range(0, 63));
      wd = $urandom;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) ad = ad & ~12'((1 << sz) - 1);
      mdl(ch, we, sz, ad, wd, erd, eer);
      run_access(ch, we, sz, ad, wd, rd, er, lat, pulse);
      vectors++;
      if (rd !== erd || er !== eer || lat != ws_of[ch] + 1 || !pulse) begin
        miscompares++;
        $display("FAIL random ch%0d we=%b sz=%0d addr=%h got rdata=%h err=%b lat=%0d single=%b exp rdata=%h err=%b lat=%0d",
                 ch, we, sz, ad, rd, er, lat, pulse, erd, eer, ws_of[ch] + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    localparam int K = 12;
    bit          b_we [K];
    logic [1:0]  b_sz [K];
    logic [11:0] b_ad [K];
    logic [31:0] b_wd [K];
    logic [31:0] q_rd [$];
    bit          q_er [$];
    logic [31:0] erd;
    bit eer, acc, prev_rv;
    int i, last_acc, nrsp;
    for (int j = 0; j < K; j++) begin
      b_we[j] = 1'($urandom_range(0, 1));
      b_sz[j] = 2'($urandom_range(0, 2));
      b_ad[j] = (12'h100 + 12'($urandom_range(0, 63))) & ~12'((1 << b_sz[j]) - 1);
      b_wd[j] = $urandom;
    end
    i = 0; last_acc = -10; nrsp = 0; prev_rv = 1'b0;
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = b_we[0]; req_size[1] = b_sz[0];
    req_addr[1] = b_ad[0]; req_wdata[1] = b_wd[0];
    for (int cyc = 0; cyc < 200 && nrsp < K; cyc++) begin
      if (rsp_valid[1]) begin
        vectors++;
        if (req_ready[1] !== 1'b0 || cyc != last_acc + 1 || prev_rv || q_rd.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_timing cyc %0d got ready=%b last_acc=%0d prev_valid=%b exp ready=0 last_acc=%0d prev_valid=0",
                   cyc, req_ready[1], last_acc, prev_rv, cyc - 1);
        end else begin
          erd = q_rd.pop_front();
          eer = q_er.pop_front();
          vectors++;
          if (rsp_rdata[1] !== erd || rsp_err[1] !== eer) begin
            miscompares++;
            $display("FAIL b2b_data rsp %0d got rdata=%h err=%b exp rdata=%h err=%b",
                     nrsp, rsp_rdata[1], rsp_err[1], erd, eer);
          end
        end
        nrsp++;
      end
      prev_rv = rsp_valid[1];
      acc = req_valid[1] && req_ready[1];
      if (acc) begin
        if (i > 0) begin
          vectors++;
          if (cyc - last_acc != 2) begin
            miscompares++;
            $display("FAIL b2b_accept_spacing got %0d cycles exp 2", cyc - last_acc);
          end
        end
        last_acc = cyc;
        mdl(1, b_we[i], b_sz[i], b_ad[i], b_wd[i], erd, eer);
        q_rd.push_back(erd);
        q_er.push_back(eer);
        i++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (i < K) begin
          req_we[1] = b_we[i]; req_size[1] = b_sz[i];
          req_addr[1] = b_ad[i]; req_wdata[1] = b_wd[i];
        end else begin
          req_valid[1] = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    vectors++;
    if (nrsp != K) begin
      miscompares++;
      $display("FAIL b2b_count got %0d responses exp %0d", nrsp, K);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd;
    bit er, eer, pulse, seen;
    int lat;
    mdl(2, 1'b1, 2'd2, 12'h020, 32'hCAFEF00D, erd, eer);
    run_access(2, 1'b1, 2'd2, 12'h020, 32'hCAFEF00D, rd, er, lat, pulse);
    mdl(2, 1'b0, 2'd2, 12'h020, 32'h0, erd, eer);
    run_access(2, 1'b0, 2'd2, 12'h020, 32'h0, rd, er, lat, pulse);
    vectors++;
    if (rd !== erd || lat != 4) begin
      miscompares++;
      $display("FAIL rstmid_pre got rdata=%h lat=%0d exp rdata=%h lat=4", rd, lat, erd);
    end
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_size[2] = 2'd2;
    req_addr[2] = 12'h020; req_wdata[2] = 32'h12345678;
    @(posedge clk);
    #1 req_valid[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    @(posedge clk);
    #1 rst[2] = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid[2]) seen = 1'b1;
    end
    vectors++;
    if (seen || req_ready[2] !== 1'b1 || rsp_rdata[2] !== 32'h0 || rsp_err[2] !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_drop got rsp_seen=%b ready=%b rdata=%h err=%b exp 0 1 0 0",
               seen, req_ready[2], rsp_rdata[2], rsp_err[2]);
    end
    run_access(2, 1'b0, 2'd2, 12'h020, 32'h0, rd, er, lat, pulse);
    vectors++;
    if (rd !== 32'hCAFEF00D || er !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_contents got rdata=%h err=%b exp rdata=cafef00d err=0", rd, er);
    end
  endtask

  task automatic test_ignore();
    logic [31:0] rd, erd;
    bit er, eer, pulse, rdy_bad;
    int lat;
    mdl(2, 1'b0, 2'd2, 12'h104, 32'h0, erd, eer);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b0; req_size[2] = 2'd2;
    req_addr[2] = 12'h104; req_wdata[2] = 32'h0;
    @(posedge clk);
    #1;
    req_we[2] = 1'b1; req_addr[2] = 12'h108; req_wdata[2] = ~{ref_mem[2][12'h10B],
      ref_mem[2][12'h10A], ref_mem[2][12'h109], ref_mem[2][12'h108]};
    lat = -1; rdy_bad = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (req_ready[2]) rdy_bad = 1'b1;
      if (rsp_valid[2]) begin
        lat = c;
        req_valid[2] = 1'b0;
        break;
      end
    end
    req_valid[2] = 1'b0;
    vectors++;
    if (rsp_rdata[2] !== erd || rsp_err[2] !== 1'b0 || lat != 4 || rdy_bad) begin
      miscompares++;
      $display("FAIL ignore_rsp got rdata=%h err=%b lat=%0d ready_seen=%b exp rdata=%h err=0 lat=4 ready_seen=0",
               rsp_rdata[2], rsp_err[2], lat, rdy_bad, erd);
    end
    mdl(2, 1'b0, 2'd2, 12'h108, 32'h0, erd, eer);
    run_access(2, 1'b0, 2'd2, 12'h108, 32'h0, rd, er, lat, pulse);
    vectors++;
    if (rd !== erd) begin
      miscompares++;
      $display("FAIL ignore_nowrite got rdata=%h exp %h", rd, erd);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_directed();
    test_random(0, 40);
    test_random(1, 40);
    test_random(2, 30);
    test_back_to_back();
    test_reset_mid();
    test_ignore();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
